// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and the write-back request record.
package mips_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic [31:0] pc;
    logic [REG_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: sync FIFO of MDU write-back requests with per-entry register match vectors.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  wb_req_t                  din,
  output wb_req_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [REG_W-1:0]         q_reg1,
  input  logic [REG_W-1:0]         q_reg2,
  output logic [DEPTH-1:0]         hit1,
  output logic [DEPTH-1:0]         hit2
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wb_req_t mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      vld <= '0;
      count <= '0;
    end else begin
      if (push) begin
        vld[wp] <= 1'b1;
        wp <= wp + 1'b1;
      end
      if (pop) begin
        vld[rp] <= 1'b0;
        rp <= rp + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  assign head = mem[rp];
  // Valid bits track occupancy per slot so stale data never raises a match.
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    assign hit1[g] = vld[g] && mem[g].rd == q_reg1;
    assign hit2[g] = vld[g] && mem[g].rd == q_reg2;
  end
endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges W-stage and MDU results onto the single GRF write port.
module grf_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_valid,
  input  logic [31:0]       p_pc,
  input  logic [REG_W-1:0]  p_reg,
  input  logic [DATA_W-1:0] p_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [31:0]       m_pc,
  input  logic [REG_W-1:0]  m_reg,
  input  logic [DATA_W-1:0] m_data,
  input  logic [REG_W-1:0]  q_reg1,
  input  logic [REG_W-1:0]  q_reg2,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic              grf_wen,
  output logic [REG_W-1:0]  grf_wreg,
  output logic [DATA_W-1:0] grf_wd,
  output logic [31:0]       grf_wpc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [CW-1:0] count;
  logic [DEPTH-1:0] hit1, hit2;
  logic accept, queued, push, pop;
  wb_req_t head, m_req;
  assign m_req = '{pc: m_pc, rd: m_reg, data: m_data};
  assign m_ready = count != FULL;
  assign accept = m_valid && m_ready;
  assign queued = count != '0;
  assign pop = !p_valid && queued;
  // An accept only queues when it cannot go straight to the output regs.
  assign push = accept && (p_valid || queued);
  assign q_busy1 = q_reg1 != '0 && (|hit1 || (accept && m_reg == q_reg1));
  assign q_busy2 = q_reg2 != '0 && (|hit2 || (accept && m_reg == q_reg2));
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(m_req), .head(head),
    .count(count), .q_reg1(q_reg1), .q_reg2(q_reg2), .hit1(hit1), .hit2(hit2)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      grf_wen <= 1'b0;
      grf_wreg <= '0;
      grf_wd <= '0;
      grf_wpc <= '0;
    end else if (p_valid) begin
      grf_wen <= 1'b1;
      grf_wreg <= p_reg;
      grf_wd <= p_data;
      grf_wpc <= p_pc;
    end else if (queued) begin
      grf_wen <= 1'b1;
      grf_wreg <= head.rd;
      grf_wd <= head.data;
      grf_wpc <= head.pc;
    end else if (accept) begin
      grf_wen <= 1'b1;
      grf_wreg <= m_reg;
      grf_wd <= m_data;
      grf_wpc <= m_pc;
    end else begin
      grf_wen <= 1'b0;
    end
  end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: scoreboard bench; expected GRF writes queued by stimulus, popped by a monitor.
module tb_grf_wb_arbiter;
  logic clk = 0, reset;
  logic p_valid, m_valid, m_ready, q_busy1, q_busy2, grf_wen;
  logic [31:0] p_pc, p_data, m_pc, m_data, grf_wd, grf_wpc;
  logic [4:0] p_reg, m_reg, q_reg1, q_reg2, grf_wreg;
  int tests = 0, fails = 0;
  typedef struct {logic [4:0] r; logic [31:0] d; logic [31:0] pc;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  grf_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .p_valid(p_valid), .p_pc(p_pc), .p_reg(p_reg), .p_data(p_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc), .m_reg(m_reg), .m_data(m_data),
    .q_reg1(q_reg1), .q_reg2(q_reg2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .grf_wen(grf_wen), .grf_wreg(grf_wreg), .grf_wd(grf_wd), .grf_wpc(grf_wpc)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pv(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    p_valid = 1; p_reg = r; p_data = d; p_pc = pc;
  endtask
  task automatic mv(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    m_valid = 1; m_reg = r; m_data = d; m_pc = pc;
  endtask
  task automatic ex(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
    sb.push_back('{r, d, pc});
  endtask
  always @(negedge clk) begin
    if (grf_wen === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got reg %0d data %h expected no write", grf_wreg, grf_wd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_reg", {27'd0, grf_wreg}, {27'd0, e.r});
        chk("wr_data", grf_wd, e.d);
        chk("wr_pc", grf_wpc, e.pc);
      end
    end
  end
  initial begin
    reset = 1; p_valid = 0; m_valid = 0; p_reg = 0; p_data = 0; p_pc = 0;
    m_reg = 0; m_data = 0; m_pc = 0; q_reg1 = 0; q_reg2 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_wen", {31'd0, grf_wen}, 0);
    chk("rst_wreg", {27'd0, grf_wreg}, 0);
    chk("rst_wd", grf_wd, 0);
    chk("rst_wpc", grf_wpc, 0);
    chk("rst_mready", {31'd0, m_ready}, 1);
    // 1: pipeline write then idle
    pv(5, 32'h11, 32'h3000); ex(5, 32'h11, 32'h3000);
    step(); p_valid = 0;
    step(); chk("idle_wen", {31'd0, grf_wen}, 0);
    // 2: MDU bypass
    mv(8, 32'hAB, 32'h3004); q_reg1 = 8; ex(8, 32'hAB, 32'h3004);
    #1 chk("byp_mready", {31'd0, m_ready}, 1);
    chk("byp_busy_acc", {31'd0, q_busy1}, 1);
    step(); m_valid = 0;
    #1 chk("byp_busy_after", {31'd0, q_busy1}, 0);
    step();
    // 3: MDU results queue behind pipeline writes
    q_reg1 = 9; q_reg2 = 10;
    pv(1, 32'h101, 32'h3010); mv(9, 32'h99, 32'h4000); ex(1, 32'h101, 32'h3010);
    #1 chk("q_mready0", {31'd0, m_ready}, 1);
    chk("q_busy9_acc", {31'd0, q_busy1}, 1);
    step(); pv(2, 32'h102, 32'h3014); mv(10, 32'hAA, 32'h4004); ex(2, 32'h102, 32'h3014);
    #1 chk("q_busy9", {31'd0, q_busy1}, 1);
    chk("q_busy10_acc", {31'd0, q_busy2}, 1);
    step(); pv(3, 32'h103, 32'h3018); m_valid = 0; ex(3, 32'h103, 32'h3018);
    #1 chk("q_full_mready", {31'd0, m_ready}, 0);
    chk("q_busy9_full", {31'd0, q_busy1}, 1);
    chk("q_busy10_full", {31'd0, q_busy2}, 1);
    step(); pv(4, 32'h104, 32'h301C); ex(4, 32'h104, 32'h301C);
    step(); p_valid = 0; ex(9, 32'h99, 32'h4000); ex(10, 32'hAA, 32'h4004);
    step(); chk("q_first9", {27'd0, grf_wreg}, 9);
    chk("q_mready1", {31'd0, m_ready}, 1);
    step(); chk("q_second10", {27'd0, grf_wreg}, 10);
    chk("q_wen10", {31'd0, grf_wen}, 1);
    step(); chk("q_drained", {31'd0, grf_wen}, 0);
    chk("q_busy_clear", {30'd0, q_busy1, q_busy2}, 0);
    // 4: full FIFO holds off a new MDU result until a pop
    pv(11, 32'h111, 32'h3020); mv(12, 32'h12, 32'h4010); ex(11, 32'h111, 32'h3020);
    step(); pv(13, 32'h113, 32'h3024); mv(14, 32'h14, 32'h4014); ex(13, 32'h113, 32'h3024);
    step(); pv(15, 32'h115, 32'h3028); mv(16, 32'h16, 32'h4018); ex(15, 32'h115, 32'h3028);
    q_reg1 = 16;
    #1 chk("full_mready", {31'd0, m_ready}, 0);
    chk("full_busy16", {31'd0, q_busy1}, 0);
    step(); p_valid = 0; ex(12, 32'h12, 32'h4010);
    #1 chk("full_pop_mready", {31'd0, m_ready}, 0);
    step(); ex(14, 32'h14, 32'h4014);
    #1 chk("after_pop_mready", {31'd0, m_ready}, 1);
    chk("held_busy16", {31'd0, q_busy1}, 1);
    step(); m_valid = 0; ex(16, 32'h16, 32'h4018);
    step(); step();
    chk("full_last16", {27'd0, grf_wreg}, 16);
    step();
    // 5: register 0 never busy, still written
    q_reg1 = 0; mv(0, 32'h55, 32'h5000); ex(0, 32'h55, 32'h5000);
    #1 chk("r0_busy", {31'd0, q_busy1}, 0);
    step(); m_valid = 0;
    chk("r0_wen", {31'd0, grf_wen}, 1);
    chk("r0_wreg", {27'd0, grf_wreg}, 0);
    step();
    // 6: reset flushes queued entries
    q_reg1 = 18; q_reg2 = 20;
    pv(17, 32'h117, 32'h3030); mv(18, 32'h18, 32'h4020); ex(17, 32'h117, 32'h3030);
    step(); pv(19, 32'h119, 32'h3034); mv(20, 32'h20, 32'h4024); ex(19, 32'h119, 32'h3034);
    step(); p_valid = 0; m_valid = 0; reset = 1;
    #1 chk("pre_rst_busy", {30'd0, q_busy1, q_busy2}, 2'b11);
    step(); reset = 0;
    chk("flush_wen", {31'd0, grf_wen}, 0);
    chk("flush_mready", {31'd0, m_ready}, 1);
    chk("flush_busy", {30'd0, q_busy1, q_busy2}, 0);
    repeat (5) step();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
